// File: rtl/ota_pkg.sv
// rtl/ota_pkg.sv - shared types and constants for the OTA output decimator
package ota_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ota_state_e;

  localparam int         BASE_WIN_LOG2 = 8;
  localparam logic [7:0] DUTY_MAX      = 8'd255;

endpackage

// File: rtl/ota_sync.sv
// rtl/ota_sync.sv - N-flop synchroniser for analog-to-digital crossings
module ota_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] ff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[N-2:0], d_i};
    end
  end

  assign q_o = ff_q[N-1];

endmodule

// File: rtl/ota_out_decimator.sv
// rtl/ota_out_decimator.sv - windowed duty-cycle and toggle measurement of the OTA output
module ota_out_decimator
  import ota_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ota_in,
  input  logic       start,
  input  logic       cont,
  input  logic       abort,
  input  logic [2:0] win_sel,
  output logic [7:0] duty,
  output logic [7:0] toggles,
  output logic       valid,
  output logic       busy,
  output logic       sync_q
);

  logic             s;
  logic             s_d_q;
  logic             edge_det;
  ota_state_e       state_q, state_d;
  logic [2:0]       k_q, k_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [7:0]       tog_q, tog_d;
  logic [7:0]       duty_q, duty_d;
  logic [7:0]       toggles_q, toggles_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] win_last;
  logic [CNT_W-1:0] scaled;

  ota_sync #(.N(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (ota_in),
    .q_o  (s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_d_q <= 1'b0;
    end else begin
      s_d_q <= s;
    end
  end

  assign edge_det = s ^ s_d_q;

  // Last cycle index of the window: 256*2^k - 1.
  assign win_last = ({{(CNT_W-1){1'b0}}, 1'b1} << (BASE_WIN_LOG2 + int'(k_q)))
                    - {{(CNT_W-1){1'b0}}, 1'b1};
  assign scaled   = ones_q >> k_q;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    ones_d    = ones_q;
    cyc_d     = cyc_q;
    tog_d     = tog_q;
    duty_d    = duty_q;
    toggles_d = toggles_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = RUN;
          k_d     = win_sel;
          ones_d  = '0;
          cyc_d   = '0;
          tog_d   = '0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          cyc_d  = cyc_q + {{(CNT_W-1){1'b0}}, 1'b1};
          ones_d = ones_q + {{(CNT_W-1){1'b0}}, s};
          if (edge_det && (tog_q != 8'hFF)) begin
            tog_d = tog_q + 8'd1;
          end
          if (cyc_q == win_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          // An all-ones window scales to 256, clipped to the 8-bit maximum.
          duty_d    = (|scaled[CNT_W-1:8]) ? DUTY_MAX : scaled[7:0];
          toggles_d = tog_q;
          valid_d   = 1'b1;
          if (cont) begin
            state_d = RUN;
            k_d     = win_sel;
            ones_d  = '0;
            cyc_d   = '0;
            tog_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      ones_q    <= '0;
      cyc_q     <= '0;
      tog_q     <= '0;
      duty_q    <= '0;
      toggles_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      ones_q    <= ones_d;
      cyc_q     <= cyc_d;
      tog_q     <= tog_d;
      duty_q    <= duty_d;
      toggles_q <= toggles_d;
      valid_q   <= valid_d;
    end
  end

  assign duty    = duty_q;
  assign toggles = toggles_q;
  assign valid   = valid_q;
  assign busy    = (state_q == RUN);
  assign sync_q  = s;

endmodule

// File: tb/tb_ota_out_decimator.sv
// tb/tb_ota_out_decimator.sv - directed self-checking bench for ota_out_decimator
module tb_ota_out_decimator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ota_in = 1'b0;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] win_sel = 3'd0;
  logic [7:0] duty;
  logic [7:0] toggles;
  logic       valid;
  logic       busy;
  logic       sync_q;

  int tests = 0;
  int failed = 0;
  int mode = 0;
  int ph = 0;

  ota_out_decimator #(.SYNC_STAGES(2), .CNT_W(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ota_in (ota_in),
    .start  (start),
    .cont   (cont),
    .abort  (abort),
    .win_sel(win_sel),
    .duty   (duty),
    .toggles(toggles),
    .valid  (valid),
    .busy   (busy),
    .sync_q (sync_q)
  );

  always #5 clk = ~clk;

  // Mode 0 leaves ota_in to the main sequence; 1 = period-4 square; 2 = 3 high of every 8.
  initial begin
    forever begin
      @(negedge clk);
      ph++;
      if (mode == 1) ota_in = ((ph % 4) < 2);
      else if (mode == 2) ota_in = ((ph % 8) < 3);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic run_window(input int k, input string tag, input logic [7:0] ed, input logic [7:0] et);
    int c;
    int len;
    bit seen;
    len = 256 << k;
    win_sel = 3'(k);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_rise"}, 32'(busy), 32'd1);
    c = 0;
    seen = 1'b0;
    while (!seen && c < 40000) begin
      @(negedge clk);
      c++;
      if (c == len) check({tag, "_busy_done"}, 32'(busy), 32'd0);
      if (valid) seen = 1'b1;
    end
    check({tag, "_latency"}, 32'(c), 32'(len + 1));
    check({tag, "_duty"}, 32'(duty), 32'(ed));
    check({tag, "_toggles"}, 32'(toggles), 32'(et));
    @(negedge clk);
    check({tag, "_valid_width"}, 32'(valid), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int c;
    int nv;
    int vpos [1:3];
    bit seen;

    idle(3);
    check("rst_duty", 32'(duty), 32'd0);
    check("rst_toggles", 32'(toggles), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    idle(3);

    // Synchroniser latency: two rising edges
    ota_in = 1'b1;
    @(negedge clk);
    check("sync_lat1", 32'(sync_q), 32'd0);
    @(negedge clk);
    check("sync_lat2", 32'(sync_q), 32'd1);
    idle(4);

    run_window(0, "ones_k0", 8'd255, 8'd0);

    // Abort at cycle 100: no valid, previous results kept
    win_sel = 3'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle(99);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (valid) seen = 1'b1;
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    check("abort_duty_kept", 32'(duty), 32'd255);
    check("abort_toggles_kept", 32'(toggles), 32'd0);

    // abort together with start in IDLE stays idle
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_idle", 32'(busy), 32'd0);

    // Reset mid-window
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle(50);
    rst_n = 1'b0;
    #1;
    check("midrst_duty", 32'(duty), 32'd0);
    check("midrst_toggles", 32'(toggles), 32'd0);
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_sync", 32'(sync_q), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    mode = 1;
    idle(10);
    run_window(2, "sq4_k2", 8'd128, 8'd255);

    mode = 2;
    idle(10);
    run_window(0, "p38_k0", 8'd96, 8'd64);

    // Continuous mode, k=1, win_sel changed mid second window
    mode = 0;
    ota_in = 1'b0;
    idle(10);
    win_sel = 3'd1;
    cont = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    nv = 0;
    vpos[1] = 0;
    vpos[2] = 0;
    vpos[3] = 0;
    while (nv < 3 && c < 2000) begin
      @(negedge clk);
      c++;
      if (c == 600) win_sel = 3'd0;
      if (valid) begin
        nv++;
        vpos[nv] = c;
        check("cont_duty", 32'(duty), 32'd0);
        if (nv == 2) cont = 1'b0;
      end
    end
    check("cont_nvalid", 32'(nv), 32'd3);
    check("cont_v1", 32'(vpos[1]), 32'd513);
    check("cont_v2", 32'(vpos[2]), 32'd1026);
    check("cont_v3_newk", 32'(vpos[3]), 32'd1283);
    @(negedge clk);
    check("cont_stop", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
